master_port: RTL
================

# master_port

Initiator end of `master_slave_if` that turns local command requests into bus transactions toward a slave. It drives `req`/`cmd`/`addr`/`wdata`, completes the `ack` handshake, and tracks outstanding reads. It returns read data from `resp`/`rdata` pulses in issue order. It sits between a local client (CPU-style or test sequencer) and the router's slave ports.

## Interface
- `DATA_WIDTH`, 32, width of `wdata`/`rdata`/`lcl_wdata`/`lcl_rdata`
- `ADDR_WIDTH`, 32, width of `addr`/`lcl_addr`
- `MAX_RD`, 4, maximum outstanding reads; matches the slave address FIFO depth
- `ACK_TIMEOUT`, 64, cycles allowed for one `ack` phase before abort
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  asynchronous, active-low reset; deassertion is synchronised externally
- `lcl_valid`  in  1  local command valid
- `lcl_ready`  out  1  local command accepted when `lcl_valid && lcl_ready`
- `lcl_cmd`  in  1  1 = write, 0 = read
- `lcl_addr`  in  ADDR_WIDTH  transaction address
- `lcl_wdata`  in  DATA_WIDTH  write data; ignored for reads
- `lcl_rvalid`  out  1  one-cycle pulse; `lcl_rdata` is valid
- `lcl_rdata`  out  DATA_WIDTH  returned read data
- `err_timeout`  out  1  one-cycle pulse on `ack` timeout
- `err_spurious`  out  1  one-cycle pulse on `resp` with no read outstanding
- `master_slave_bus`  modport MASTER  —  drives `req`, `cmd`, `addr`, `wdata`; samples `ack`, `resp`, `rdata`

## Operation
- The slave holds `ack` high when idle. After seeing `req` rise, it drops `ack`. It raises `ack` again once it has taken the write, or has queued the read address.
- Issue FSM has four states:
  - IDLE: `lcl_ready` = 1 unless (`lcl_cmd` = 0 and `rd_cnt` == MAX_RD). On handshake, register `cmd`/`addr`/`wdata` and go to REQ.
  - REQ: `req` = 1. When `ack` is sampled low, go to WAIT_ACK.
  - WAIT_ACK: `req` = 1. When `ack` is sampled high, the transaction is accepted. A read increments `rd_cnt`. Go to GAP.
  - GAP: `req` = 0 for exactly 2 cycles (counter), then go to IDLE.
- `cmd`, `addr` and `wdata` stay stable from the REQ entry through the WAIT_ACK exit.
- Timeout counter:
  - Cleared on entry to REQ and on the REQ→WAIT_ACK transition.
  - Increments each cycle in REQ or WAIT_ACK.
  - On reaching ACK_TIMEOUT-1: pulse `err_timeout`, drop `req`, go to GAP. `rd_cnt` is not incremented.
- Read return path runs independently of the FSM:
  - Register `resp` into `resp_d1`; a rising edge is `resp && !resp_d1`.
  - Rising edge with `rd_cnt` > 0: capture `rdata` into `lcl_rdata`, pulse `lcl_rvalid` on the next cycle, decrement `rd_cnt`.
  - Rising edge with `rd_cnt` == 0: pulse `err_spurious`. `lcl_rvalid` stays 0 and `rd_cnt` is unchanged.
  - A multi-cycle `resp` level counts once.
- Simultaneous read acceptance and `resp` edge: `rd_cnt` is unchanged (+1 and -1 both applied).
- `rd_cnt` is `$clog2(MAX_RD+1)` bits wide. It never exceeds MAX_RD and never underflows.
- Write completion needs nothing further once `ack` rises.

## Timing
- Reset values:
  - State = IDLE, `rd_cnt` = 0, `resp_d1` = 0, timeout counter = 0.
  - `req` = 0, `cmd` = 0, `addr` = 0, `wdata` = 0.
  - `lcl_ready` = 1, `lcl_rvalid` = 0, `lcl_rdata` = 0.
  - `err_timeout` = 0, `err_spurious` = 0.
- `req` goes high the cycle after the local handshake.
- `lcl_ready` falls the cycle after a handshake. It returns high in the cycle after GAP ends, so the minimum back-to-back spacing is handshake + REQ(≥1) + WAIT_ACK(≥1) + GAP(2).
- `lcl_rvalid` comes 1 cycle after the `resp` rising edge is sampled. `lcl_rdata` holds its value until the next capture.
- Assertion of `rst` mid-transaction drops `req` immediately (asynchronously). Outstanding reads are discarded and `rd_cnt` = 0.
- All outputs are registered; there is no combinational path from bus inputs to local outputs. `lcl_ready` is the one exception: it is combinational from state, `rd_cnt` and `lcl_cmd`.

## Test plan
- **Single write:** `lcl_cmd`=1, `lcl_addr`=0x10, `lcl_wdata`=0xDEADBEEF.
  - Required: `req` high next cycle with `cmd`=1 and `addr`/`wdata` stable.
  - Slave model drops `ack` 1 cycle later and raises it 2 cycles later. `req` then drops and `lcl_ready` returns after 2 GAP cycles.
- **Single read:** read from 0x10. Slave raises `ack`, then pulses `resp` 14 cycles later with `rdata`=0xDEADBEEF.
  - Required: one `lcl_rvalid` pulse with `lcl_rdata`=0xDEADBEEF; `rd_cnt` goes 0→1→0.
- **Read back-pressure:** issue 5 reads with `resp` withheld.
  - Required: 4 reads are accepted. `lcl_ready` stays 0 for the 5th read while `rd_cnt`=4, and the 5th read issues after the first `resp` edge.
  - Data returns in order: 0xA0, 0xA1, 0xA2, 0xA3, 0xA4.
- **Timeout:** slave never drops `ack`.
  - Required: `err_timeout` pulses once ACK_TIMEOUT cycles after `req` rose, `req` drops, `rd_cnt` stays 0, and the FSM returns to IDLE.
- **Spurious and held `resp`:**
  - `resp` held high for 3 cycles with `rd_cnt`=1: exactly one `lcl_rvalid`.
  - A later `resp` pulse with `rd_cnt`=0: `err_spurious`=1 for 1 cycle and `lcl_rvalid`=0.
- **Reset mid-operation:** assert `rst`=0 during WAIT_ACK with `rd_cnt`=2.
  - Required: `req`=0 and `rd_cnt`=0 immediately, and all outputs at their reset values.
  - After release, a new write completes normally.

Source files
------------

// File: rtl/master_port_if.sv
// Point-to-point bus between an initiator and a slave port:
// req/cmd/addr/wdata forward, ack/resp/rdata back.
interface master_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic                  cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic                  resp;
    logic [DATA_WIDTH-1:0] rdata;

    modport MASTER (
        output req, cmd, addr, wdata,
        input  ack, resp, rdata
    );

    modport SLAVE (
        input  req, cmd, addr, wdata,
        output ack, resp, rdata
    );
endinterface

// File: rtl/master_port.sv
// Bus initiator: issues local commands with a req/ack handshake,
// bounds outstanding reads and returns read data in issue order.
module master_port #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MAX_RD      = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lcl_valid,
    output logic                  lcl_ready,
    input  logic                  lcl_cmd,
    input  logic [ADDR_WIDTH-1:0] lcl_addr,
    input  logic [DATA_WIDTH-1:0] lcl_wdata,
    output logic                  lcl_rvalid,
    output logic [DATA_WIDTH-1:0] lcl_rdata,
    output logic                  err_timeout,
    output logic                  err_spurious,
    master_slave_if.MASTER        master_slave_bus
);
    localparam int CW = $clog2(MAX_RD + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CMAX  = CW'(MAX_RD);
    localparam logic [TW-1:0] TLAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, GAP} state_t;

    state_t                state, state_n;
    logic [TW-1:0]         tcnt, tcnt_n;
    logic                  gcnt, gcnt_n;
    logic                  req_q, req_n;
    logic                  tout_n;
    logic                  rd_acc;
    logic                  cmd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CW-1:0]         rd_cnt;
    logic                  resp_d1;
    logic                  hshk;
    logic                  resp_rise;
    logic                  rd_ret;

    assign lcl_ready = (state == IDLE) && !(!lcl_cmd && rd_cnt == CMAX);
    assign hshk      = lcl_valid && lcl_ready;
    assign resp_rise = master_slave_bus.resp && !resp_d1;
    assign rd_ret    = resp_rise && (rd_cnt != '0);

    assign master_slave_bus.req   = req_q;
    assign master_slave_bus.cmd   = cmd_q;
    assign master_slave_bus.addr  = addr_q;
    assign master_slave_bus.wdata = wdata_q;

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        gcnt_n  = gcnt;
        req_n   = req_q;
        tout_n  = 1'b0;
        rd_acc  = 1'b0;
        unique case (state)
            IDLE: begin
                if (hshk) begin
                    state_n = REQ;
                    tcnt_n  = '0;
                    req_n   = 1'b1;
                end
            end
            REQ: begin
                if (tcnt == TLAST) begin
                    state_n = GAP;
                    gcnt_n  = 1'b0;
                    req_n   = 1'b0;
                    tout_n  = 1'b1;
                end else if (!master_slave_bus.ack) begin
                    state_n = WAIT_ACK;
                    tcnt_n  = '0;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (tcnt == TLAST) begin
                    state_n = GAP;
                    gcnt_n  = 1'b0;
                    req_n   = 1'b0;
                    tout_n  = 1'b1;
                end else if (master_slave_bus.ack) begin
                    state_n = GAP;
                    gcnt_n  = 1'b0;
                    req_n   = 1'b0;
                    rd_acc  = !cmd_q;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            GAP: begin
                if (gcnt) state_n = IDLE;
                else      gcnt_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            gcnt        <= 1'b0;
            req_q       <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            tcnt        <= tcnt_n;
            gcnt        <= gcnt_n;
            req_q       <= req_n;
            err_timeout <= tout_n;
        end
    end

    // Acceptance and return in the same cycle cancel out in rd_cnt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_cnt       <= '0;
            resp_d1      <= 1'b0;
            lcl_rvalid   <= 1'b0;
            lcl_rdata    <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (hshk) begin
                cmd_q   <= lcl_cmd;
                addr_q  <= lcl_addr;
                wdata_q <= lcl_wdata;
            end
            resp_d1      <= master_slave_bus.resp;
            lcl_rvalid   <= rd_ret;
            err_spurious <= resp_rise && (rd_cnt == '0);
            if (rd_ret) lcl_rdata <= master_slave_bus.rdata;
            rd_cnt <= rd_cnt + CW'(rd_acc) - CW'(rd_ret);
        end
    end
endmodule
